// File: rtl/uart_pkg.sv
// Shared definitions for the UART controller family.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index width for an n-entry selector; a single entry still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority selector: first asserted request after last_grant, with wrap.
module rr_pick
    import uart_pkg::*;
#(
    parameter  int unsigned N = 4,
    localparam int unsigned W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] pick,
    output logic         any
);

    int unsigned idx;

    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last_grant) + k) % N;
            if (!any && req[W'(idx)]) begin
                any  = 1'b1;
                pick = W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx among N_REQ byte streams.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned N_REQ      = 4,
    parameter  int unsigned DATA_WIDTH = UART_DATA_WIDTH,
    parameter  int unsigned MAX_BURST  = 16,
    localparam int unsigned GW         = idx_width(N_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]                 req_valid,
    input  logic [N_REQ-1:0]                 req_last,
    output logic [N_REQ-1:0]                 req_ready,
    output logic [DATA_WIDTH-1:0]            tx_data,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic [GW-1:0]                    grant_id,
    output logic                             busy
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    arb_state_t     state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  last_q, last_d;
    logic [CW-1:0]  count_q, count_d;
    logic [GW-1:0]  pick;
    logic           pick_any;

    rr_pick #(.N(N_REQ)) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_q),
        .pick       (pick),
        .any        (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(N_REQ - 1);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // Owner pass-through is gated during reset so nothing leaks while rst is high.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        count_d   = count_q;
        tx_data   = '0;
        tx_valid  = 1'b0;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick;
                    count_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!rst) begin
                    tx_data            = req_data[grant_q];
                    tx_valid           = req_valid[grant_q];
                    req_ready[grant_q] = tx_ready;
                end
                if (req_valid[grant_q] && tx_ready) begin
                    count_d = count_q + CW'(1);
                    if (req_last[grant_q] || (count_q == CW'(MAX_BURST - 1))) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == GRANT);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed sequences, random traffic.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0][7:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [1:0]      grant_id;
    logic            busy;

    uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(8), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-requester pending bytes: {last, data}; transfer log entries: id*256+data.
    logic [8:0] q[N][$];
    int         tlog[$];
    int         exp_log[$];
    int         pushed;

    // Reference model state, kept at packet/grant level with plain integers.
    int m_owner;
    int m_gid;
    int m_last;
    int m_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int r, input int len, input int base);
        for (int i = 0; i < len; i++) begin
            q[r].push_back({(i == len - 1) ? 1'b1 : 1'b0, 8'(base + i)});
            pushed++;
        end
    endtask

    // One clock cycle: drive from the queues, check against the model, advance the model.
    task automatic cyc(input logic [N-1:0] en, input logic tr, input logic r);
        logic [N-1:0]      v;
        logic [N-1:0]      l;
        logic [N-1:0][7:0] d;
        logic [1:0]        oi;
        for (int i = 0; i < N; i++) begin
            v[i] = en[i] && (q[i].size() > 0);
            d[i] = v[i] ? q[i][0][7:0] : 8'h00;
            l[i] = v[i] ? q[i][0][8] : 1'b0;
        end
        rst = r; req_valid = v; req_last = l; req_data = d; tx_ready = tr;
        #1;
        if (r) begin
            chk("rst_tx_valid", int'(tx_valid), 0);
            chk("rst_req_ready", int'(req_ready), 0);
            m_owner = -1; m_gid = 0; m_last = N - 1; m_cnt = 0;
        end else if (m_owner < 0) begin
            chk("idle_busy", int'(busy), 0);
            chk("idle_grant_id", int'(grant_id), m_gid);
            chk("idle_tx_valid", int'(tx_valid), 0);
            chk("idle_req_ready", int'(req_ready), 0);
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && v[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    m_gid   = m_owner;
                    m_cnt   = 0;
                end
            end
        end else begin
            oi = 2'(m_owner);
            chk("grant_busy", int'(busy), 1);
            chk("grant_id", int'(grant_id), m_owner);
            chk("grant_tx_valid", int'(tx_valid), int'(v[oi]));
            if (v[oi]) chk("grant_tx_data", int'(tx_data), int'(d[oi]));
            chk("grant_req_ready", int'(req_ready), tr ? (1 << m_owner) : 0);
            if (v[oi] && tr) begin
                tlog.push_back(m_owner * 256 + int'(d[oi]));
                void'(q[oi].pop_front());
                m_cnt++;
                if (l[oi] || m_cnt == MB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
        @(negedge clk);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        cyc('0, 1'b1, 1'b1);
        tlog.delete();
        exp_log.delete();
        pushed = 0;
    endtask

    task automatic drain(input int limit);
        int c;
        c = 0;
        while (c < limit && !(all_empty() && m_owner < 0)) begin
            cyc('1, 1'b1, 1'b0);
            c++;
        end
        chk("drain_done", int'(all_empty() && m_owner < 0), 1);
    endtask

    task automatic chk_log(input string name);
        chk({name, "_len"}, tlog.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < tlog.size(); i++)
            chk(name, tlog[i], exp_log[i]);
    endtask

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic [7:0] d;
        logic       tr;
        logic       e_busy;
        logic [1:0] e_gid;
        logic       e_tv;
        logic [7:0] e_td;
        logic [3:0] e_rr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
        m_owner = -1; m_gid = 0; m_last = N - 1; m_cnt = 0; pushed = 0;

        // Single requester: req1 sends 0x41..0x43, then a backpressured 1-byte packet.
        vecs[0] = '{4'b0010, 4'b0000, 8'h41, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000};
        vecs[1] = '{4'b0010, 4'b0000, 8'h41, 1'b1, 1'b1, 2'd1, 1'b1, 8'h41, 4'b0010};
        vecs[2] = '{4'b0010, 4'b0000, 8'h42, 1'b1, 1'b1, 2'd1, 1'b1, 8'h42, 4'b0010};
        vecs[3] = '{4'b0010, 4'b0010, 8'h43, 1'b1, 1'b1, 2'd1, 1'b1, 8'h43, 4'b0010};
        vecs[4] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00, 4'b0000};
        vecs[5] = '{4'b1000, 4'b1000, 8'h99, 1'b0, 1'b0, 2'd1, 1'b0, 8'h00, 4'b0000};
        vecs[6] = '{4'b1000, 4'b1000, 8'h99, 1'b0, 1'b1, 2'd3, 1'b1, 8'h99, 4'b0000};
        vecs[7] = '{4'b1000, 4'b1000, 8'h99, 1'b1, 1'b1, 2'd3, 1'b1, 8'h99, 4'b1000};

        @(negedge clk);
        cyc('0, 1'b1, 1'b1);
        rst = 1'b0;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_grant_id", int'(grant_id), 0);
        chk("reset_tx_valid", int'(tx_valid), 0);
        chk("reset_req_ready", int'(req_ready), 0);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            req_valid = vecs[i].v; req_last = vecs[i].l; tx_ready = vecs[i].tr;
            for (int r = 0; r < N; r++) req_data[r] = vecs[i].d;
            #1;
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
            chk($sformatf("vec%0d_grant_id", i), int'(grant_id), int'(vecs[i].e_gid));
            chk($sformatf("vec%0d_tx_valid", i), int'(tx_valid), int'(vecs[i].e_tv));
            if (vecs[i].e_tv) chk($sformatf("vec%0d_tx_data", i), int'(tx_data), int'(vecs[i].e_td));
            chk($sformatf("vec%0d_req_ready", i), int'(req_ready), int'(vecs[i].e_rr));
            @(negedge clk);
        end
        req_valid = '0; req_last = '0;

        // Round-robin fairness with all four requesters holding 1-byte packets.
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < N; r++) push_pkt(r, 1, 8'h10 + r);
        drain(100);
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < N; r++) exp_log.push_back(r * 256 + 8'h10 + r);
        chk_log("rr_order");

        // Forced rotation: 20-byte packet from req0 while req2 waits.
        do_reset();
        push_pkt(0, 20, 0);
        push_pkt(2, 1, 8'hA2);
        drain(200);
        for (int i = 0; i < 16; i++) exp_log.push_back(i);
        exp_log.push_back(2 * 256 + 8'hA2);
        for (int i = 16; i < 20; i++) exp_log.push_back(i);
        chk_log("forced_rot");

        // Backpressure: tx_ready high one cycle in four during req3's packet.
        do_reset();
        push_pkt(3, 5, 8'h30);
        for (int c = 0; c < 60 && !(all_empty() && m_owner < 0); c++)
            cyc('1, (c % 4) == 0, 1'b0);
        for (int i = 0; i < 5; i++) exp_log.push_back(3 * 256 + 8'h30 + i);
        chk_log("backpressure");

        // Owner stall: req2 drops valid for 50 cycles while req0 waits.
        do_reset();
        push_pkt(2, 4, 8'h21);
        push_pkt(0, 1, 8'h01);
        for (int c = 0; c < 3; c++) cyc(4'b0100, 1'b1, 1'b0);
        for (int c = 0; c < 50; c++) cyc(4'b0001, 1'b1, 1'b0);
        drain(100);
        for (int i = 0; i < 4; i++) exp_log.push_back(2 * 256 + 8'h21 + i);
        exp_log.push_back(8'h01);
        chk_log("owner_stall");

        // Reset mid-packet: req1 interrupted after 2 of 4 bytes, req0 then wins.
        do_reset();
        push_pkt(1, 4, 8'h51);
        for (int c = 0; c < 3; c++) cyc(4'b0010, 1'b1, 1'b0);
        push_pkt(0, 1, 8'h60);
        cyc(4'b0011, 1'b1, 1'b1);
        cyc(4'b0011, 1'b1, 1'b0);
        chk("rst_mid_first_pick", m_owner, 0);
        drain(100);
        exp_log.push_back(1 * 256 + 8'h51);
        exp_log.push_back(1 * 256 + 8'h52);
        exp_log.push_back(8'h60);
        exp_log.push_back(1 * 256 + 8'h53);
        exp_log.push_back(1 * 256 + 8'h54);
        chk_log("rst_mid");

        // Random traffic against the model, packet lengths long enough to force rotation.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] en;
            for (int r = 0; r < N; r++) begin
                if (q[r].size() == 0 && $urandom_range(0, 7) == 0)
                    push_pkt(r, $urandom_range(1, 22), $urandom_range(0, 255));
                en[r] = ($urandom_range(0, 7) != 0);
            end
            cyc(en, $urandom_range(0, 3) != 0, 1'b0);
        end
        drain(2000);
        chk("rand_byte_count", tlog.size(), pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
